// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one operation to a registered ALU, waits out its
//                pipeline latency and returns result/flags over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int LENGTH      = 8,
    parameter int ALU_LATENCY = 2,
    parameter int CHECK_PARAM = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LENGTH-1:0] req_a,
    input  logic [LENGTH-1:0] req_b,
    input  logic [3:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [LENGTH-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              alu_en,
    output logic [LENGTH-1:0] alu_a,
    output logic [LENGTH-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [LENGTH-1:0] alu_result,
    input  logic              alu_carry_f,
    input  logic              alu_overflow_f,
    input  logic              alu_zero_f
);

    localparam logic [1:0] c_idle          = 2'd0;
    localparam logic [1:0] c_exec          = 2'd1;
    localparam logic [1:0] c_capture       = 2'd2;
    localparam logic [1:0] c_resp          = 2'd3;
    localparam logic [1:0] c_latency       = ALU_LATENCY[1:0];
    localparam logic [3:0] c_last_legal_op = 4'd9;

    generate
        if ((CHECK_PARAM != 0) && ((LENGTH < 4) || (ALU_LATENCY > 2) || (ALU_LATENCY < 0))) begin : g_param_check
            $fatal(1, "alu_op_sequencer: LENGTH must be >= 4 and ALU_LATENCY in 0..2");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_cnt;
    logic [LENGTH-1:0] r_alu_a;
    logic [LENGTH-1:0] r_alu_b;
    logic [3:0]        r_alu_ctrl;
    logic [LENGTH-1:0] r_rsp_result;
    logic              r_rsp_carry;
    logic              r_rsp_overflow;
    logic              r_rsp_zero;
    logic              r_rsp_err;
    logic              w_illegal;

    assign w_illegal = (req_op > c_last_legal_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_next_state = c_resp;
                    end else if (c_latency == 2'd0) begin
                        w_next_state = c_capture;
                    end else begin
                        w_next_state = c_exec;
                    end
                end
            end
            // Leave on the last enabled cycle so the ALU sees exactly ALU_LATENCY en cycles
            c_exec: begin
                if (r_cnt <= 2'd1) begin
                    w_next_state = c_capture;
                end
            end
            c_capture: w_next_state = c_resp;
            c_resp: begin
                if (rsp_ready) begin
                    w_next_state = c_idle;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= 2'd0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_ctrl     <= 4'd0;
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            // Rejected opcodes never touch the ALU operand registers
                            r_rsp_result   <= '0;
                            r_rsp_carry    <= 1'b0;
                            r_rsp_overflow <= 1'b0;
                            r_rsp_zero     <= 1'b0;
                            r_rsp_err      <= 1'b1;
                        end else begin
                            r_alu_a    <= req_a;
                            r_alu_b    <= req_b;
                            r_alu_ctrl <= req_op;
                            r_cnt      <= c_latency;
                        end
                    end
                end
                c_exec: r_cnt <= r_cnt - 2'd1;
                c_capture: begin
                    r_rsp_result   <= alu_result;
                    r_rsp_carry    <= alu_carry_f;
                    r_rsp_overflow <= alu_overflow_f;
                    r_rsp_zero     <= alu_zero_f;
                    r_rsp_err      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == c_idle);
    assign rsp_valid    = (r_state == c_resp);
    assign alu_en       = (r_state == c_exec);
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ctrl     = r_alu_ctrl;
    assign rsp_result   = r_rsp_result;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed bench for alu_op_sequencer, 2-stage and 0-stage ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int ens;
    int seen;

    // Two-stage ALU instance signals
    logic       d2_req_valid = 1'b0, d2_req_ready, d2_rsp_valid, d2_rsp_ready = 1'b0;
    logic [7:0] d2_req_a = '0, d2_req_b = '0, d2_rsp_result, d2_alu_a, d2_alu_b, d2_alu_result;
    logic [3:0] d2_req_op = '0, d2_alu_ctrl;
    logic       d2_rsp_carry, d2_rsp_overflow, d2_rsp_zero, d2_rsp_err, d2_alu_en;
    logic       d2_alu_carry_f, d2_alu_overflow_f, d2_alu_zero_f;

    // Combinational ALU instance signals
    logic       d0_req_valid = 1'b0, d0_req_ready, d0_rsp_valid, d0_rsp_ready = 1'b0;
    logic [7:0] d0_req_a = '0, d0_req_b = '0, d0_rsp_result, d0_alu_a, d0_alu_b, d0_alu_result;
    logic [3:0] d0_req_op = '0, d0_alu_ctrl;
    logic       d0_rsp_carry, d0_rsp_overflow, d0_rsp_zero, d0_rsp_err, d0_alu_en;
    logic       d0_alu_carry_f, d0_alu_overflow_f, d0_alu_zero_f;

    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = -b;
            4'd3: r = a * b;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = ~a;
            4'd7: r = a ^ b;
            4'd8: r = a << b[2:0];
            4'd9: r = a >> b[2:0];
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    // Behavioural ALU with input and output register stages, both gated by en
    logic [7:0] m2_a = '0, m2_b = '0;
    logic [3:0] m2_op = '0;
    logic [9:0] m2_out = '0;
    always @(posedge clk) begin
        if (d2_alu_en) begin
            m2_a   <= d2_alu_a;
            m2_b   <= d2_alu_b;
            m2_op  <= d2_alu_ctrl;
            m2_out <= alu_fn(m2_a, m2_b, m2_op);
        end
    end
    assign d2_alu_result     = m2_out[7:0];
    assign d2_alu_carry_f    = m2_out[9];
    assign d2_alu_overflow_f = m2_out[8];
    assign d2_alu_zero_f     = (m2_out[7:0] == 8'h00);

    logic [9:0] m0_out;
    assign m0_out            = alu_fn(d0_alu_a, d0_alu_b, d0_alu_ctrl);
    assign d0_alu_result     = m0_out[7:0];
    assign d0_alu_carry_f    = m0_out[9];
    assign d0_alu_overflow_f = m0_out[8];
    assign d0_alu_zero_f     = (m0_out[7:0] == 8'h00);

    alu_op_sequencer #(.LENGTH(8), .ALU_LATENCY(2), .CHECK_PARAM(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d2_req_valid), .req_ready(d2_req_ready),
        .req_a(d2_req_a), .req_b(d2_req_b), .req_op(d2_req_op),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready),
        .rsp_result(d2_rsp_result), .rsp_carry(d2_rsp_carry),
        .rsp_overflow(d2_rsp_overflow), .rsp_zero(d2_rsp_zero), .rsp_err(d2_rsp_err),
        .alu_en(d2_alu_en), .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_ctrl(d2_alu_ctrl),
        .alu_result(d2_alu_result), .alu_carry_f(d2_alu_carry_f),
        .alu_overflow_f(d2_alu_overflow_f), .alu_zero_f(d2_alu_zero_f)
    );

    alu_op_sequencer #(.LENGTH(8), .ALU_LATENCY(0), .CHECK_PARAM(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready),
        .req_a(d0_req_a), .req_b(d0_req_b), .req_op(d0_req_op),
        .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
        .rsp_result(d0_rsp_result), .rsp_carry(d0_rsp_carry),
        .rsp_overflow(d0_rsp_overflow), .rsp_zero(d0_rsp_zero), .rsp_err(d0_rsp_err),
        .alu_en(d0_alu_en), .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_ctrl(d0_alu_ctrl),
        .alu_result(d0_alu_result), .alu_carry_f(d0_alu_carry_f),
        .alu_overflow_f(d0_alu_overflow_f), .alu_zero_f(d0_alu_zero_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept2(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        d2_req_a = a; d2_req_b = b; d2_req_op = op; d2_req_valid = 1'b1;
        tick();
        d2_req_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge (1) up to the first edge with rsp_valid high
    task automatic wait_rsp2();
        lat = 1; ens = 0;
        while (!d2_rsp_valid && lat < 12) begin
            if (d2_alu_en) ens++;
            tick();
            lat++;
        end
    endtask

    task automatic release2();
        d2_rsp_ready = 1'b1;
        tick();
        d2_rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_req_ready", d2_req_ready, 1);
        chk("rst_rsp_valid", d2_rsp_valid, 0);
        chk("rst_alu_en", d2_alu_en, 0);
        chk("rst_rsp_result", d2_rsp_result, 0);
        chk("rst_rsp_err", d2_rsp_err, 0);
        chk("rst_alu_ctrl", d2_alu_ctrl, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ADD overflow
        accept2(8'h7F, 8'h01, 4'd0);
        chk("add_alu_a", d2_alu_a, 8'h7F);
        wait_rsp2();
        chk("add_latency", lat, 4);
        chk("add_en_cycles", ens, 2);
        chk("add_result", d2_rsp_result, 8'h80);
        chk("add_overflow", d2_rsp_overflow, 1);
        chk("add_zero", d2_rsp_zero, 0);
        chk("add_err", d2_rsp_err, 0);
        release2();
        chk("add_rsp_drop", d2_rsp_valid, 0);
        chk("add_ready_back", d2_req_ready, 1);

        // SUB to zero
        accept2(8'h05, 8'h05, 4'd1);
        wait_rsp2();
        chk("sub_latency", lat, 4);
        chk("sub_result", d2_rsp_result, 8'h00);
        chk("sub_zero", d2_rsp_zero, 1);
        chk("sub_overflow", d2_rsp_overflow, 0);
        release2();

        // Illegal opcode
        accept2(8'hEE, 8'hDD, 4'hC);
        wait_rsp2();
        chk("ill_latency", lat, 1);
        chk("ill_en_cycles", ens, 0);
        chk("ill_err", d2_rsp_err, 1);
        chk("ill_result", d2_rsp_result, 8'h00);
        chk("ill_flags", {d2_rsp_carry, d2_rsp_overflow, d2_rsp_zero}, 3'b000);
        chk("ill_alu_a_held", d2_alu_a, 8'h05);
        chk("ill_alu_b_held", d2_alu_b, 8'h05);
        chk("ill_alu_ctrl_held", d2_alu_ctrl, 4'd1);
        release2();

        // SHL with back-pressure and a competing request
        accept2(8'h03, 8'h02, 4'd8);
        wait_rsp2();
        chk("shl_latency", lat, 4);
        d2_req_a = 8'h01; d2_req_b = 8'h01; d2_req_op = 4'd0; d2_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("shl_hold_result", d2_rsp_result, 8'h0C);
            chk("shl_hold_valid", d2_rsp_valid, 1);
            chk("shl_hold_ready", d2_req_ready, 0);
            tick();
        end
        chk("shl_hold_alu_a", d2_alu_a, 8'h03);
        d2_rsp_ready = 1'b1;
        tick();
        d2_rsp_ready = 1'b0;
        chk("shl_idle_valid", d2_rsp_valid, 0);
        chk("shl_idle_en", d2_alu_en, 0);
        chk("shl_not_taken", d2_alu_a, 8'h03);
        tick();
        d2_req_valid = 1'b0;
        chk("second_taken_en", d2_alu_en, 1);
        chk("second_taken_a", d2_alu_a, 8'h01);
        wait_rsp2();
        chk("second_result", d2_rsp_result, 8'h02);
        release2();

        // Reset during the second EXEC cycle of MUL
        accept2(8'h04, 8'h03, 4'd3);
        tick();
        chk("mul_exec2_en", d2_alu_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_alu_en", d2_alu_en, 0);
        chk("mrst_req_ready", d2_req_ready, 1);
        chk("mrst_alu_a", d2_alu_a, 8'h00);
        chk("mrst_alu_ctrl", d2_alu_ctrl, 4'd0);
        tick();
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (d2_rsp_valid) seen++;
        end
        chk("mrst_no_rsp", seen, 0);
        accept2(8'h10, 8'h20, 4'd0);
        wait_rsp2();
        chk("post_rst_latency", lat, 4);
        chk("post_rst_result", d2_rsp_result, 8'h30);
        release2();

        // Zero-latency build: XOR
        d0_req_a = 8'hAA; d0_req_b = 8'hFF; d0_req_op = 4'd7; d0_req_valid = 1'b1;
        tick();
        d0_req_valid = 1'b0;
        chk("l0_en_capture", d0_alu_en, 0);
        chk("l0_valid_early", d0_rsp_valid, 0);
        tick();
        chk("l0_valid", d0_rsp_valid, 1);
        chk("l0_en_resp", d0_alu_en, 0);
        chk("l0_result", d0_rsp_result, 8'h55);
        chk("l0_zero", d0_rsp_zero, 0);
        d0_rsp_ready = 1'b1;
        tick();
        d0_rsp_ready = 1'b0;
        chk("l0_ready_back", d0_req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side sequencer for the registered ALU. It accepts one operation request over a valid/ready handshake and drives operands, opcode and enable into the ALU. It waits out the ALU's pipeline latency, captures the result and flags, and returns them over a valid/ready response channel. It sits between the multi-cycle control path and the ALU, hiding the ALU's register-stage timing from requesters.

Parameters:
LENGTH, 8, operand/result width; must match the attached ALU; must be >= 4.
ALU_LATENCY, 2, number of en-asserted cycles the ALU needs before its outputs are valid: 0 = fully combinational, 1 = one register stage, 2 = input and output registers. Legal range 0..2.
CHECK_PARAM, 1, when 1, simulation-only fatal if LENGTH < 4 or ALU_LATENCY > 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  LENGTH  operand A
req_b  input  LENGTH  operand B
req_op  input  4  opcode, ALU_ctrl_e encoding
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_result  output  LENGTH  captured ALU result
rsp_carry  output  1  captured carry flag
rsp_overflow  output  1  captured overflow flag
rsp_zero  output  1  captured zero flag
rsp_err  output  1  opcode was illegal; operation not issued
alu_en  output  1  ALU enable
alu_a  output  LENGTH  ALU operand A
alu_b  output  LENGTH  ALU operand B
alu_ctrl  output  4  ALU opcode (ALU_ctrl_e)
alu_result  input  LENGTH  ALU result
alu_carry_f  input  1  ALU carry flag
alu_overflow_f  input  1  ALU overflow flag
alu_zero_f  input  1  ALU zero flag

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n), and clears all state regardless of the clock.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_carry=0; rsp_overflow=0; rsp_zero=0; rsp_err=0; alu_en=0; alu_a=0; alu_b=0; alu_ctrl=0 (ADD); cycle counter=0.
- Legal opcodes: 0..9 (ADD, SUB, NEG_B, MUL, AND, OR, A_N, XOR, SHL, SHR). Opcodes 10..15 are illegal.
- FSM states: IDLE, EXEC, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with a legal opcode: register req_a, req_b, req_op into alu_a, alu_b, alu_ctrl; load counter with ALU_LATENCY; go to EXEC, or to CAPTURE if ALU_LATENCY=0.
  - On req_valid with an illegal opcode: go directly to RESP with rsp_err=1, rsp_result=0 and all flags 0. alu_en is never asserted and alu_a/alu_b/alu_ctrl are unchanged.
- EXEC:
  - alu_en=1 and req_ready=0.
  - alu_a, alu_b, alu_ctrl are held stable.
  - Counter decrements each cycle; move to CAPTURE in the cycle the counter reaches 1 (exactly ALU_LATENCY en cycles).
- CAPTURE:
  - alu_en=0, so ALU registers hold.
  - Register alu_result and alu_*_f into the rsp_* outputs; rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - All rsp_* outputs hold stable until rsp_ready=1, then return to IDLE (rsp_valid=0 the next cycle).
  - No request is accepted in RESP.
- Latency from request acceptance edge to rsp_valid high:
  - legal opcode: ALU_LATENCY+2 cycles.
  - illegal opcode: 1 cycle.
- Throughput: at most one operation in flight; the minimum issue interval is ALU_LATENCY+3 cycles.
- alu_en is asserted only in EXEC, so the ALU never advances on stale or unissued operands.
- Reset mid-operation (any state): immediate return to reset values. Any in-flight operation is discarded and no response is produced.
- rsp_ready high outside RESP is ignored. req_* inputs are don't-care when req_ready=0.

Test Plan:
- LATENCY=2, ADD a=8'h7F b=8'h01 -> alu_en high for exactly 2 cycles; rsp_valid 4 cycles after accept; rsp_result=8'h80, rsp_overflow=1, rsp_zero=0, rsp_err=0.
- SUB a=8'h05 b=8'h05 -> rsp_result=8'h00, rsp_zero=1, rsp_overflow=0.
- Illegal req_op=4'hC -> rsp_valid one cycle after accept; rsp_err=1, rsp_result=0; alu_en never asserted; alu_a/alu_b/alu_ctrl unchanged.
- SHL a=8'h03 b=8'h02 with rsp_ready held low 5 cycles in RESP -> rsp_result=8'h0C held stable throughout; req_ready=0; a second req_valid is not accepted until 1 cycle after rsp_ready rises.
- Assert rst_n=0 during the second EXEC cycle of MUL 8'h04*8'h03 -> asynchronous return to reset values; no rsp_valid; next request completes normally.
- LATENCY=0 build, XOR 8'hAA^8'hFF -> alu_en never high; rsp_valid 2 cycles after accept; rsp_result=8'h55.
